// File: rtl/atm_pkg.sv
// Shared op codes, response status codes and FSM state encoding for the ATM session arbiter.
package atm_pkg;

  localparam logic [2:0] BALANCE    = 3'd0;
  localparam logic [2:0] WITHDRAW   = 3'd1;
  localparam logic [2:0] DEPOSIT    = 3'd2;
  localparam logic [2:0] CHANGE_PIN = 3'd3;
  localparam logic [2:0] LOGOUT     = 3'd4;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    TIMEOUT = 2'b01,
    BAD_OP  = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic logic op_valid(input logic [2:0] op);
    return op <= LOGOUT;
  endfunction

endpackage

// File: rtl/atm_session_arbiter_if.sv
// Terminal-side request/response bundle plus the core-side operand/completion signals.
interface atm_session_arbiter_if #(
  parameter int N_TERM = 4
);
  logic [N_TERM-1:0]    req;
  logic [3*N_TERM-1:0]  req_operation;
  logic [4*N_TERM-1:0]  req_acc_num;
  logic [16*N_TERM-1:0] req_pin;
  logic [16*N_TERM-1:0] req_newpin;
  logic [16*N_TERM-1:0] req_amount;
  logic [N_TERM-1:0]    req_language;
  logic [N_TERM-1:0]    grant;
  logic                 core_start;
  logic [2:0]           core_operation;
  logic [3:0]           core_acc_num;
  logic [15:0]          core_pin;
  logic [15:0]          core_newpin;
  logic [15:0]          core_amount;
  logic                 core_language;
  logic                 core_done;
  logic [15:0]          core_balance;
  logic [N_TERM-1:0]    rsp_valid;
  logic [15:0]          rsp_balance;
  logic [1:0]           rsp_status;

  // Environment side: terminals and the ATM core.
  modport master (
    output req, req_operation, req_acc_num, req_pin, req_newpin, req_amount, req_language,
    output core_done, core_balance,
    input  grant, core_start, core_operation, core_acc_num, core_pin, core_newpin,
    input  core_amount, core_language, rsp_valid, rsp_balance, rsp_status
  );

  // Arbiter side.
  modport slave (
    input  req, req_operation, req_acc_num, req_pin, req_newpin, req_amount, req_language,
    input  core_done, core_balance,
    output grant, core_start, core_operation, core_acc_num, core_pin, core_newpin,
    output core_amount, core_language, rsp_valid, rsp_balance, rsp_status
  );
endinterface

// File: rtl/atm_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N_TERM-1.
module atm_rr_pick #(
  parameter  int N_TERM = 4,
  localparam int IW     = $clog2(N_TERM)
) (
  input  logic [N_TERM-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [IW-1:0]     winner,
  output logic              any_req
);

  always_comb begin
    logic [IW-1:0] idx;
    idx     = '0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = 0; k < N_TERM; k++) begin
      idx = IW'((int'(ptr) + k) % N_TERM);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/atm_session_arbiter.sv
// Round-robin owner of the single ATM core: latch winner's operands, strobe start, await done/timeout, respond.
// Grant and core_start one cycle after req is sampled in IDLE; rsp_valid one cycle after core_done.
module atm_session_arbiter #(
  parameter int N_TERM         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 rst,
  atm_session_arbiter_if.slave bus
);
  import atm_pkg::*;

  localparam int IW = $clog2(N_TERM);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [N_TERM-1:0] grant_q, grant_d;
  logic [IW-1:0]     win_q, win_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              core_start_q, core_start_d;
  logic [2:0]        op_q, op_d;
  logic [3:0]        acc_q, acc_d;
  logic [15:0]       pin_q, pin_d;
  logic [15:0]       newpin_q, newpin_d;
  logic [15:0]       amount_q, amount_d;
  logic              lang_q, lang_d;
  logic [N_TERM-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]       rsp_balance_q, rsp_balance_d;
  status_e           rsp_status_q, rsp_status_d;

  logic [IW-1:0]     pick_win;
  logic              pick_any;

  atm_rr_pick #(.N_TERM(N_TERM)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .winner  (pick_win),
    .any_req (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    win_d         = win_q;
    ptr_d         = ptr_q;
    timer_d       = timer_q;
    core_start_d  = 1'b0;
    op_d          = op_q;
    acc_d         = acc_q;
    pin_d         = pin_q;
    newpin_d      = newpin_q;
    amount_d      = amount_q;
    lang_d        = lang_q;
    rsp_valid_d   = '0;
    rsp_balance_d = rsp_balance_q;
    rsp_status_d  = rsp_status_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          win_d   = pick_win;
          grant_d = '0;
          for (int i = 0; i < N_TERM; i++) begin
            if (pick_win == IW'(i)) begin
              grant_d[i] = 1'b1;
              op_d       = bus.req_operation[3*i +: 3];
              acc_d      = bus.req_acc_num[4*i +: 4];
              pin_d      = bus.req_pin[16*i +: 16];
              newpin_d   = bus.req_newpin[16*i +: 16];
              amount_d   = bus.req_amount[16*i +: 16];
              lang_d     = bus.req_language[i];
            end
          end
          // Invalid op codes never reach the core; answer straight away.
          if (op_valid(op_d)) begin
            state_d      = ISSUE;
            core_start_d = 1'b1;
          end else begin
            state_d       = RESP;
            rsp_valid_d   = grant_d;
            rsp_status_d  = BAD_OP;
            rsp_balance_d = '0;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.core_done) begin
          state_d       = RESP;
          rsp_valid_d   = grant_q;
          rsp_status_d  = OK;
          rsp_balance_d = bus.core_balance;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d       = RESP;
          rsp_valid_d   = grant_q;
          rsp_status_d  = TIMEOUT;
          rsp_balance_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        grant_d = '0;
        ptr_d   = (win_q == IW'(N_TERM - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      win_q         <= '0;
      ptr_q         <= '0;
      timer_q       <= '0;
      core_start_q  <= 1'b0;
      op_q          <= '0;
      acc_q         <= '0;
      pin_q         <= '0;
      newpin_q      <= '0;
      amount_q      <= '0;
      lang_q        <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_balance_q <= '0;
      rsp_status_q  <= OK;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      win_q         <= win_d;
      ptr_q         <= ptr_d;
      timer_q       <= timer_d;
      core_start_q  <= core_start_d;
      op_q          <= op_d;
      acc_q         <= acc_d;
      pin_q         <= pin_d;
      newpin_q      <= newpin_d;
      amount_q      <= amount_d;
      lang_q        <= lang_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_balance_q <= rsp_balance_d;
      rsp_status_q  <= rsp_status_d;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.core_start     = core_start_q;
  assign bus.core_operation = op_q;
  assign bus.core_acc_num   = acc_q;
  assign bus.core_pin       = pin_q;
  assign bus.core_newpin    = newpin_q;
  assign bus.core_amount    = amount_q;
  assign bus.core_language  = lang_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_balance    = rsp_balance_q;
  assign bus.rsp_status     = rsp_status_q;

endmodule

// File: tb/tb_atm_session_arbiter.sv
// Bench for atm_session_arbiter: directed scenarios plus randomized sessions against a round-robin reference model.
module tb_atm_session_arbiter;
  import atm_pkg::*;

  localparam int N = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_session_arbiter_if #(.N_TERM(N)) bus ();

  atm_session_arbiter #(.N_TERM(N), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0] grant;
    int           gcyc;
    int           starts;
    int           scyc;
    logic [N-1:0] rv;
    int           rcyc;
    logic [15:0]  bal;
    logic [1:0]   st;
    logic [2:0]   op;
    logic [3:0]   acc;
    logic [15:0]  amt;
    logic         lang;
    logic         stable;
    logic         ok;
  } obs_t;

  int n_checks = 0;
  int n_pass   = 0;
  int mdl_ptr  = 0;

  logic [2:0]  f_op     [N];
  logic [3:0]  f_acc    [N];
  logic [15:0] f_pin    [N];
  logic [15:0] f_newpin [N];
  logic [15:0] f_amt    [N];
  logic        f_lang   [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      bus.req_operation[3*i +: 3] = f_op[i];
      bus.req_acc_num[4*i +: 4]   = f_acc[i];
      bus.req_pin[16*i +: 16]     = f_pin[i];
      bus.req_newpin[16*i +: 16]  = f_newpin[i];
      bus.req_amount[16*i +: 16]  = f_amt[i];
      bus.req_language[i]         = f_lang[i];
    end
  endtask

  task automatic randomize_fields(input bit allow_bad);
    for (int i = 0; i < N; i++) begin
      f_op[i]     = allow_bad ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      f_acc[i]    = 4'($urandom);
      f_pin[i]    = 16'($urandom);
      f_newpin[i] = 16'($urandom);
      f_amt[i]    = 16'($urandom);
      f_lang[i]   = 1'($urandom);
    end
  endtask

  // Plays the core for one session: replies d cycles after core_start (d<0: never).
  // Scrambles terminal fields after the grant to expose unlatched operands.
  task automatic run_session(input int d, input logic [15:0] bal, output obs_t o);
    o.grant = '0; o.gcyc = -1; o.starts = 0; o.scyc = -1; o.rv = '0; o.rcyc = -1;
    o.bal = '0; o.st = '0; o.op = '0; o.acc = '0; o.amt = '0; o.lang = 1'b0;
    o.stable = 1'b1; o.ok = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      bus.core_done    = 1'b0;
      bus.core_balance = 16'($urandom);
      if (bus.grant != '0 && o.gcyc < 0) begin
        o.grant = bus.grant; o.gcyc = c;
        o.op = bus.core_operation; o.acc = bus.core_acc_num;
        o.amt = bus.core_amount; o.lang = bus.core_language;
        randomize_fields(1'b0);
        drive_fields();
      end else if (o.gcyc >= 0) begin
        if (bus.core_operation !== o.op || bus.core_acc_num !== o.acc ||
            bus.core_amount !== o.amt || bus.core_language !== o.lang)
          o.stable = 1'b0;
      end
      if (bus.core_start === 1'b1) begin
        o.starts++;
        if (o.scyc < 0) o.scyc = c;
      end
      if (d >= 0 && o.scyc >= 0 && c == o.scyc + d) begin
        bus.core_done    = 1'b1;
        bus.core_balance = bal;
      end
      if (bus.rsp_valid != '0) begin
        o.rv = bus.rsp_valid; o.rcyc = c; o.bal = bus.rsp_balance; o.st = bus.rsp_status;
        o.ok = 1'b1;
        break;
      end
    end
    bus.core_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", bus.grant); else n_pass++;
    n_checks++; if (bus.core_start !== 1'b0) $display("FAIL reset_core_start: got %b want 0", bus.core_start); else n_pass++;
    n_checks++; if ({bus.core_operation, bus.core_acc_num, bus.core_pin, bus.core_newpin, bus.core_amount, bus.core_language} !== 56'd0)
      $display("FAIL reset_operands: got %h want 0", {bus.core_operation, bus.core_acc_num, bus.core_pin, bus.core_newpin, bus.core_amount, bus.core_language}); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); else n_pass++;
    n_checks++; if ({bus.rsp_balance, bus.rsp_status} !== 18'd0) $display("FAIL reset_rsp: got %h want 0", {bus.rsp_balance, bus.rsp_status}); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    obs_t o;
    randomize_fields(1'b0);
    f_op[0] = WITHDRAW; f_amt[0] = 16'd100; f_acc[0] = 4'd7; f_lang[0] = 1'b1;
    drive_fields();
    bus.req = 4'b0001;
    run_session(3, 16'd900, o);
    n_checks++; if (o.grant !== 4'b0001 || o.gcyc != 1) $display("FAIL basic_grant: got %b@%0d want 0001@1", o.grant, o.gcyc); else n_pass++;
    n_checks++; if (o.starts != 1 || o.scyc != 1) $display("FAIL basic_start: got %0d starts @%0d want 1@1", o.starts, o.scyc); else n_pass++;
    n_checks++; if (o.op !== WITHDRAW || o.amt !== 16'd100 || o.acc !== 4'd7 || o.lang !== 1'b1)
      $display("FAIL basic_operands: got op%0d amt%0d acc%0d lang%0d want 1/100/7/1", o.op, o.amt, o.acc, o.lang); else n_pass++;
    n_checks++; if (o.rv !== 4'b0001 || o.rcyc != 5) $display("FAIL basic_rsp_valid: got %b@%0d want 0001@5", o.rv, o.rcyc); else n_pass++;
    n_checks++; if (o.bal !== 16'd900 || o.st !== 2'b00) $display("FAIL basic_rsp: got %0d/%b want 900/00", o.bal, o.st); else n_pass++;
    n_checks++; if (o.stable !== 1'b1) $display("FAIL basic_stable: got %b want 1", o.stable); else n_pass++;
    bus.req = '0;
    tick();
    mdl_ptr = 1;
  endtask

  task automatic test_round_robin();
    obs_t o;
    logic [N-1:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1; bus.req = '0;
    tick();
    rst = 1'b0;
    randomize_fields(1'b0);
    drive_fields();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_session(2, 16'(16'h100 + i), o);
      n_checks++; if (o.grant !== exp_seq[i] || o.gcyc != (i == 0 ? 1 : 2))
        $display("FAIL rr%0d_grant: got %b@%0d want %b@%0d", i, o.grant, o.gcyc, exp_seq[i], (i == 0 ? 1 : 2)); else n_pass++;
      n_checks++; if (o.rv !== exp_seq[i] || o.st !== 2'b00 || o.bal !== 16'(16'h100 + i) || o.rcyc != o.gcyc + 3)
        $display("FAIL rr%0d_rsp: got %b/%b/%h@%0d", i, o.rv, o.st, o.bal, o.rcyc); else n_pass++;
    end
    bus.req = '0;
    tick();
    mdl_ptr = 1;
  endtask

  task automatic test_bad_op();
    obs_t o;
    f_op[2] = 3'd6;
    drive_fields();
    bus.req = 4'b0100;
    run_session(1, 16'hFFFF, o);
    n_checks++; if (o.grant !== 4'b0100 || o.starts != 0) $display("FAIL badop_grant: got %b starts %0d want 0100 starts 0", o.grant, o.starts); else n_pass++;
    n_checks++; if (o.rv !== 4'b0100 || o.rcyc != 1) $display("FAIL badop_rsp_valid: got %b@%0d want 0100@1", o.rv, o.rcyc); else n_pass++;
    n_checks++; if (o.st !== 2'b10 || o.bal !== 16'd0) $display("FAIL badop_rsp: got %b/%0d want 10/0", o.st, o.bal); else n_pass++;
    bus.req = '0;
    tick();
    n_checks++; if (bus.grant !== 4'b0000 || bus.rsp_valid !== 4'b0000) $display("FAIL badop_idle: got %b/%b want 0000/0000", bus.grant, bus.rsp_valid); else n_pass++;
    mdl_ptr = 3;
  endtask

  task automatic test_timeout();
    obs_t o;
    f_op[3] = BALANCE;
    drive_fields();
    bus.req = 4'b1000;
    run_session(-1, 16'd0, o);
    n_checks++; if (o.starts != 1 || o.scyc != 1) $display("FAIL timeout_start: got %0d@%0d want 1@1", o.starts, o.scyc); else n_pass++;
    n_checks++; if (o.rv !== 4'b1000 || o.rcyc != 2 + T) $display("FAIL timeout_rsp_valid: got %b@%0d want 1000@%0d", o.rv, o.rcyc, 2 + T); else n_pass++;
    n_checks++; if (o.st !== 2'b01 || o.bal !== 16'd0) $display("FAIL timeout_rsp: got %b/%0d want 01/0", o.st, o.bal); else n_pass++;
    bus.req = '0;
    tick();
    n_checks++; if (bus.grant !== 4'b0000) $display("FAIL timeout_release: got %b want 0000", bus.grant); else n_pass++;
    mdl_ptr = 0;
  endtask

  task automatic test_timeout_tie();
    obs_t o;
    f_op[0] = DEPOSIT;
    drive_fields();
    bus.req = 4'b0001;
    run_session(T, 16'h5A5A, o);
    n_checks++; if (o.rv !== 4'b0001 || o.rcyc != 2 + T) $display("FAIL tie_rsp_valid: got %b@%0d want 0001@%0d", o.rv, o.rcyc, 2 + T); else n_pass++;
    n_checks++; if (o.st !== 2'b00 || o.bal !== 16'h5A5A) $display("FAIL tie_rsp: got %b/%h want 00/5a5a", o.st, o.bal); else n_pass++;
    bus.req = '0;
    tick();
    mdl_ptr = 1;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    f_op[1] = CHANGE_PIN;
    drive_fields();
    bus.req = 4'b0010;
    run_session(2, 16'h1234, o);
    n_checks++; if (o.grant !== 4'b0010 || o.bal !== 16'h1234) $display("FAIL rmid_pre: got %b/%h want 0010/1234", o.grant, o.bal); else n_pass++;
    bus.req = '0;
    tick();
    f_op[2] = LOGOUT;
    drive_fields();
    bus.req = 4'b0100;
    tick();
    n_checks++; if (bus.grant !== 4'b0100 || bus.core_start !== 1'b1) $display("FAIL rmid_issue: got %b/%b want 0100/1", bus.grant, bus.core_start); else n_pass++;
    bus.req = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (bus.grant !== 4'b0000 || bus.core_start !== 1'b0 || bus.rsp_valid !== 4'b0000)
      $display("FAIL rmid_ctrl: got %b/%b/%b want 0000/0/0000", bus.grant, bus.core_start, bus.rsp_valid); else n_pass++;
    n_checks++; if ({bus.core_operation, bus.core_acc_num, bus.core_pin, bus.core_newpin, bus.core_amount, bus.core_language, bus.rsp_balance, bus.rsp_status} !== 74'd0)
      $display("FAIL rmid_data: got %h want 0", {bus.core_operation, bus.core_acc_num, bus.core_pin, bus.core_newpin, bus.core_amount, bus.core_language, bus.rsp_balance, bus.rsp_status}); else n_pass++;
    rst = 1'b0;
    randomize_fields(1'b0);
    drive_fields();
    bus.req = 4'b1111;
    run_session(2, 16'h00AA, o);
    n_checks++; if (o.grant !== 4'b0001 || o.gcyc != 1 || o.rv !== 4'b0001) $display("FAIL rmid_ptr: got %b@%0d rv %b want 0001@1 rv 0001", o.grant, o.gcyc, o.rv); else n_pass++;
    bus.req = 4'b1000;
    run_session(3, 16'h0BBB, o);
    n_checks++; if (o.grant !== 4'b1000 || o.rv !== 4'b1000 || o.st !== 2'b00 || o.bal !== 16'h0BBB || o.rcyc != o.gcyc + 4)
      $display("FAIL rmid_fresh: got %b/%b/%b/%h@%0d", o.grant, o.rv, o.st, o.bal, o.rcyc); else n_pass++;
    bus.req = '0;
    tick();
    mdl_ptr = 0;
  endtask

  task automatic test_random();
    obs_t o;
    logic [N-1:0] r, e_grant;
    logic [2:0]   e_op;
    logic [15:0]  e_amt, bal, e_bal;
    logic [1:0]   e_st;
    int           w, d, lead, e_rcyc, e_starts;
    lead = 1;
    for (int s = 0; s < 30; s++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      randomize_fields(1'b1);
      drive_fields();
      bus.req = r;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && r[(mdl_ptr + k) % N]) w = (mdl_ptr + k) % N;
      e_grant = '0; e_grant[w] = 1'b1;
      e_op = f_op[w]; e_amt = f_amt[w];
      d = $urandom_range(0, 10);
      bal = 16'($urandom);
      run_session(d, bal, o);
      if (e_op > 3'd4) begin
        e_starts = 0; e_rcyc = lead; e_st = 2'b10; e_bal = '0;
      end else if (d >= 1 && d <= T) begin
        e_starts = 1; e_rcyc = lead + d + 1; e_st = 2'b00; e_bal = bal;
      end else begin
        e_starts = 1; e_rcyc = lead + T + 1; e_st = 2'b01; e_bal = '0;
      end
      mdl_ptr = (w + 1) % N;
      n_checks++; if (o.grant !== e_grant || o.gcyc != lead) $display("FAIL rnd%0d_grant: got %b@%0d want %b@%0d", s, o.grant, o.gcyc, e_grant, lead); else n_pass++;
      n_checks++; if (o.starts != e_starts) $display("FAIL rnd%0d_starts: got %0d want %0d", s, o.starts, e_starts); else n_pass++;
      n_checks++; if (o.op !== e_op || o.amt !== e_amt) $display("FAIL rnd%0d_operands: got %0d/%h want %0d/%h", s, o.op, o.amt, e_op, e_amt); else n_pass++;
      n_checks++; if (o.rv !== e_grant || o.rcyc != e_rcyc) $display("FAIL rnd%0d_rsp_valid: got %b@%0d want %b@%0d", s, o.rv, o.rcyc, e_grant, e_rcyc); else n_pass++;
      n_checks++; if (o.st !== e_st || o.bal !== e_bal) $display("FAIL rnd%0d_rsp: got %b/%h want %b/%h", s, o.st, o.bal, e_st, e_bal); else n_pass++;
      n_checks++; if (o.stable !== 1'b1) $display("FAIL rnd%0d_stable: got %b want 1", s, o.stable); else n_pass++;
      if ($urandom_range(0, 1) == 1) begin
        bus.req = '0;
        tick();
        lead = 1;
      end else begin
        lead = 2;
      end
    end
    bus.req = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.core_done = 1'b0;
    bus.core_balance = '0;
    for (int i = 0; i < N; i++) begin
      f_op[i] = '0; f_acc[i] = '0; f_pin[i] = '0; f_newpin[i] = '0; f_amt[i] = '0; f_lang[i] = 1'b0;
    end
    drive_fields();
    test_reset();
    test_basic();
    test_round_robin();
    test_bad_op();
    test_timeout();
    test_timeout_tie();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
